// File: rtl/regfile_multiport.sv
// Multi-read-port register file with a self-clearing controller.
//
// After reset (or a clear request in READY) the controller walks the array from
// address 0 to DEPTH-1, writing zero one word per cycle; accesses are ignored
// while clearing. In READY, one byte-enabled write port and NUM_RD registered
// read ports (1-cycle latency) are active. Out-of-range accesses leave the array
// alone, read back zero, and raise a one-cycle addr_err pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_req         re-clear the array (honoured in READY only)
//   wr_en/addr/data/be  write port, wr_be bit i enables byte i
//   rd_en/addr      per-port read strobe, packed addresses
//   rd_data/valid   packed registered read data and per-port valid
//   init_busy       high while clearing
//   addr_err        pulse for any out-of-range access in the previous cycle
//   key_id          constant block identifier
module regfile_multiport #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NUM_RD = 2,
  parameter bit          BYPASS = 1'b1,
  parameter logic [15:0] KEY_ID = 16'h0032
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     init_busy,
  output logic                     addr_err,
  output logic [15:0]              key_id
);

  localparam int unsigned       NumBytes = DATA_W / 8;
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StClear, StReady} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]         mem_q [DEPTH];
  logic [NUM_RD*DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]         rd_valid_q, rd_valid_d;
  logic                      addr_err_q, addr_err_d;

  logic                      wr_in_range, wr_ok;
  logic [ADDR_W-1:0]         wr_idx;
  logic [DATA_W-1:0]         wr_merged;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_waddr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [ADDR_W-1:0]         rd_addr_p [NUM_RD];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DepthW;
  endfunction

  // Write path: the merged word feeds both the array and the read bypass.
  always_comb begin
    wr_in_range = in_range(wr_addr);
    wr_ok       = wr_en & wr_in_range & (state_q == StReady);
    wr_idx      = wr_in_range ? wr_addr : '0;
    wr_merged   = mem_q[wr_idx];
    for (int unsigned b = 0; b < NumBytes; b++) begin
      if (wr_be[b]) wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
    end
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    mem_wdata = wr_merged;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (wr_ok && (wr_be != '0)) begin
      mem_we = 1'b1;
    end
  end

  // Controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StClear: begin
        if (cnt_q == LastAddr) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_addr_p[p] = rd_addr[p*ADDR_W +: ADDR_W];
    end
  end

  // Read ports and error flag; everything is suppressed while clearing.
  always_comb begin
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    addr_err_d = wr_en & ~wr_in_range;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (rd_en[p]) begin
        rd_valid_d[p] = 1'b1;
        if (!in_range(rd_addr_p[p])) begin
          addr_err_d                   = 1'b1;
          rd_data_d[p*DATA_W +: DATA_W] = '0;
        end else if (BYPASS && wr_ok && (rd_addr_p[p] == wr_addr)) begin
          rd_data_d[p*DATA_W +: DATA_W] = wr_merged;
        end else begin
          rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_addr_p[p]];
        end
      end
    end
    if (state_q != StReady) begin
      rd_valid_d = '0;
      rd_data_d  = rd_data_q;
      addr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Array has no reset of its own; the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign addr_err  = addr_err_q;
  assign init_busy = (state_q == StClear);
  assign key_id    = KEY_ID;

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int NR    = 2;
  localparam bit BYP   = 1'b1;

  logic             clk = 1'b0;
  logic             rst, clr_req, wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [3:0]       wr_be;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic             init_busy, addr_err;
  logic [15:0]      key_id;

  regfile_multiport #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(BYP), .KEY_ID(16'h0032)
  ) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .init_busy(init_busy), .addr_err(addr_err), .key_id(key_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic mon_on = 1'b0;

  // Reference model and scoreboard.
  logic [DW-1:0] mem_m [1024];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            err_q[$];   // cycles at which addr_err must be high
  int            rst_q[$];   // cycles at which rd_data must have been zeroed
  logic [DW-1:0] hold [NR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 6) return AW'($urandom_range(0, 15));
    if (r < 9) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(DEPTH, 1023));
  endfunction

  // One READY-state cycle. use_k replaces the model's read values with fixed constants.
  task automatic op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic [3:0] be, input logic [1:0] re, input logic [AW-1:0] ra0,
                    input logic [AW-1:0] ra1, input logic use_k, input logic [DW-1:0] k0,
                    input logic [DW-1:0] k1);
    logic [DW-1:0] merged, e;
    logic [AW-1:0] ra;
    logic          err;
    clr_req = 1'b0; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = {ra1, ra0};
    err    = 1'b0;
    merged = mem_m[wa];
    for (int b = 0; b < 4; b++) if (be[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
    for (int p = 0; p < NR; p++) begin
      ra = (p == 0) ? ra0 : ra1;
      if (re[p]) begin
        if (int'(ra) >= DEPTH) begin
          e = '0; err = 1'b1;
        end else if (BYP && we && int'(wa) < DEPTH && wa == ra) begin
          e = merged;
        end else begin
          e = mem_m[ra];
        end
        if (use_k) e = (p == 0) ? k0 : k1;
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
    end
    if (we) begin
      if (int'(wa) >= DEPTH) err = 1'b1;
      else mem_m[wa] = merged;
    end
    if (err) err_q.push_back(cyc + 1);
    tick();
    idle();
  endtask

  task automatic rand_op();
    op(1'($urandom), rand_addr(), $urandom, 4'($urandom), 2'($urandom), rand_addr(),
       rand_addr(), 1'b0, '0, '0);
  endtask

  task automatic garbage();
    clr_req = 1'($urandom); wr_en = 1'($urandom); wr_addr = AW'($urandom);
    wr_data = $urandom; wr_be = 4'($urandom); rd_en = 2'($urandom); rd_addr = 20'($urandom);
  endtask

  // Drive junk while init_busy is high; count busy cycles, optionally stop early.
  task automatic run_clear(input int abort_at, output int n);
    n = 0;
    while (init_busy === 1'b1 && n < DEPTH + 8) begin
      if (abort_at > 0 && n == abort_at) break;
      n++;
      garbage();
      tick();
    end
    idle();
    if (abort_at == 0) for (int i = 0; i < 1024; i++) mem_m[i] = '0;
  endtask

  task automatic do_rst(input logic [1:0] re);
    idle();
    rst = 1'b1; rd_en = re; rd_addr = {rand_addr(), rand_addr()};
    rst_q.push_back(cyc + 1);
    tick();
    rst = 1'b0;
    idle();
  endtask

  // Monitor: pops expected read data whenever a port presents valid data.
  initial begin
    logic [DW-1:0] act;
    logic          exp_err;
    hold[0] = '0; hold[1] = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (rst_q.size() > 0 && rst_q[0] == cyc) begin
          void'(rst_q.pop_front());
          hold[0] = '0; hold[1] = '0;
        end
        exp_err = 1'b0;
        if (err_q.size() > 0 && err_q[0] == cyc) begin
          void'(err_q.pop_front());
          exp_err = 1'b1;
        end
        chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
        for (int p = 0; p < NR; p++) begin
          act = rd_data[p*DW +: DW];
          if (rd_valid[p]) begin
            if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
              checks++; errors++;
              $display("FAIL rd_valid%0d: unexpected valid, data %h (cycle %0d)", p, act, cyc);
            end else begin
              hold[p] = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk($sformatf("rd_data%0d", p), act, hold[p]);
            end
          end else begin
            chk($sformatf("rd_hold%0d", p), act, hold[p]);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    rst = 1'b1;
    #1;
    chk("key_id_rst", {16'h0, key_id}, 32'h0032);
    tick();
    tick();
    chk("rst_rd_valid", {30'b0, rd_valid}, 32'h0);
    chk("rst_rd_data0", rd_data[31:0], 32'h0);
    chk("rst_rd_data1", rd_data[63:32], 32'h0);
    chk("rst_addr_err", {31'b0, addr_err}, 32'h0);
    chk("rst_busy", {31'b0, init_busy}, 32'h1);
    mon_on = 1'b1;
    rst = 1'b0;
    run_clear(0, n);
    chk("clear_cycles", n, DEPTH);
    chk("ready_busy", {31'b0, init_busy}, 32'h0);

    // Both boundary words read zero on both ports together.
    op(1'b0, '0, '0, '0, 2'b11, AW'(0), AW'(DEPTH - 1), 1'b1, 32'h0, 32'h0);
    chk("rd_valid_both", {30'b0, rd_valid}, 32'h3);

    // Byte-enable merge, then same-address read on both ports.
    op(1'b1, AW'(5), 32'hDEADBEEF, 4'hF, 2'b00, '0, '0, 1'b0, '0, '0);
    op(1'b1, AW'(5), 32'h0000AA00, 4'b0010, 2'b00, '0, '0, 1'b0, '0, '0);
    op(1'b0, '0, '0, '0, 2'b11, AW'(5), AW'(5), 1'b1, 32'hDEADAAEF, 32'hDEADAAEF);

    // Write-first collision on port 1.
    op(1'b1, AW'(7), 32'h12345678, 4'hF, 2'b10, '0, AW'(7), 1'b1, '0, 32'h12345678);

    // Out-of-range write and read in the same cycle.
    op(1'b1, AW'(1010), 32'hCAFEF00D, 4'hF, 2'b01, AW'(1020), '0, 1'b1, 32'h0, '0);
    op(1'b0, '0, '0, '0, 2'b00, '0, '0, 1'b0, '0, '0);
    op(1'b0, '0, '0, '0, 2'b11, AW'(5), AW'(7), 1'b1, 32'hDEADAAEF, 32'h12345678);

    for (int i = 0; i < 400; i++) rand_op();

    // Reset with reads in flight: no valid may follow.
    do_rst(2'b11);
    run_clear(0, n);
    chk("clear_after_rst", n, DEPTH);
    for (int i = 0; i < 100; i++) rand_op();

    // Clear request, then reset partway through the clear.
    clr_req = 1'b1;
    tick();
    idle();
    run_clear(300, n);
    chk("clear_abort_at", n, 300);
    chk("busy_mid_clear", {31'b0, init_busy}, 32'h1);
    do_rst(2'($urandom));
    run_clear(0, n);
    chk("clear_restart", n, DEPTH);
    op(1'b0, '0, '0, '0, 2'b11, AW'(5), AW'(7), 1'b1, 32'h0, 32'h0);

    for (int i = 0; i < 200; i++) rand_op();

    // Full clear via request from READY.
    clr_req = 1'b1;
    tick();
    idle();
    run_clear(0, n);
    chk("clear_req_cycles", n, DEPTH);
    for (int i = 0; i < 100; i++) rand_op();

    tick();
    tick();
    chk("drain_q0", exp_q0.size(), 0);
    chk("drain_q1", exp_q1.size(), 0);
    chk("drain_err", err_q.size(), 0);
    chk("key_id", {16'h0, key_id}, 32'h0032);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 Parameter DATA_W, default 32: data word width; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024: number of words.
REQ-003 Parameter ADDR_W, default 10: address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 Parameter NUM_RD, default 2: number of independent read ports, 1..4.
REQ-005 Parameter BYPASS, default 1: 1 = write-first on read/write collision, 0 = read-old.
REQ-006 Parameter KEY_ID, default 16'h0032: constant block identifier.
REQ-007 Ports SHALL be as follows; clk is the single clock; rst is synchronous, active-high:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  clr_req  in  1  request re-clear of entire array
  wr_en  in  1  write strobe
  wr_addr  in  ADDR_W  write address
  wr_data  in  DATA_W  write data
  wr_be  in  DATA_W/8  byte enables, bit i covers byte i
  rd_en  in  NUM_RD  per-port read strobe
  rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
  rd_data  out  NUM_RD*DATA_W  packed registered read data
  rd_valid  out  NUM_RD  per-port read-data valid
  init_busy  out  1  clear sequence in progress
  addr_err  out  1  one-cycle pulse on any out-of-range access
  key_id  out  16  constant KEY_ID

Function
REQ-008 Controller SHALL have two states: CLEAR and READY.
REQ-009 CLEAR SHALL write all-zero to one address per cycle, counter 0..DEPTH-1 ascending; after writing DEPTH-1 the next state SHALL be READY; init_busy SHALL be 1 exactly while in CLEAR.
REQ-010 In READY, clr_req=1 SHALL reset the counter to 0 and enter CLEAR next cycle; clr_req in CLEAR SHALL be ignored (no restart).
REQ-011 While in CLEAR, wr_en and rd_en SHALL be ignored: no array update, rd_valid=0, no addr_err.
REQ-012 In READY, wr_en=1 with wr_addr<DEPTH SHALL update only bytes with wr_be[i]=1 at the rising edge; other bytes hold.
REQ-013 Reads SHALL have 1-cycle latency: rd_en[p]=1 in cycle N -> rd_valid[p]=1 and rd_data port p valid in N+1; rd_en[p]=0 -> rd_valid[p]=0 in N+1, rd_data port p holds previous value.
REQ-014 All NUM_RD ports SHALL read simultaneously and independently, including the same address.
REQ-015 Read and write of same address in same cycle, BYPASS=1: rd_data SHALL return stored word merged with wr_data on enabled bytes; BYPASS=0: pre-write word.
REQ-016 Write with wr_addr>=DEPTH SHALL not modify the array and SHALL pulse addr_err next cycle.
REQ-017 Read with rd_addr>=DEPTH SHALL return all-zero with rd_valid=1 and pulse addr_err next cycle.
REQ-018 addr_err SHALL be the OR of all out-of-range events of the previous cycle, one cycle wide per event cycle.
REQ-019 key_id SHALL equal KEY_ID at all times, including during reset.
REQ-020 wr_be=0 with wr_en=1 SHALL be a no-op, not an error.

Reset
REQ-021 rst=1 at a rising edge SHALL force state CLEAR, counter 0, rd_valid=0, rd_data=0, addr_err=0; init_busy SHALL be 1 from the following cycle.
REQ-022 rst asserted mid-CLEAR or mid-access SHALL restart clear from address 0; in-flight reads SHALL be discarded (rd_valid=0).
REQ-023 After rst deasserts, READY SHALL be reached exactly DEPTH cycles later; all words SHALL read zero.

Verification
REQ-024 Reset, then count init_busy-high cycles -> exactly 1024; read addr 0 and 1023 on ports 0/1 -> 32'h0, rd_valid=2'b11 one cycle after rd_en.
REQ-025 Write 32'hDEADBEEF to addr 5 wr_be=4'hF, then wr_be=4'b0010 data 32'h0000AA00 -> read addr 5 returns 32'hDEADAAEF.
REQ-026 Same cycle write addr 7 data 32'h12345678 be=4'hF and read addr 7 port 1 -> BYPASS=1: 32'h12345678; BYPASS=0: prior value 32'h0.
REQ-027 DEPTH=1000, write addr 1010 and read addr 1020 -> array unchanged, rd_data 32'h0 with rd_valid=1, addr_err one-cycle pulse.
REQ-028 clr_req in READY after writes -> init_busy 1 for DEPTH cycles, writes during clear ignored, all words 0 afterwards; rst asserted at clear count 300 -> clear restarts from 0, init_busy high for full DEPTH cycles after release.
